r88_intctl: RTL
===============

R88_INTCTL -- requirements
Module: r88_intctl

Interface
REQ-001 SHALL have port sysClock, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port resetReq, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port nmiReq, input, 1, NMI request; rising-edge sensitive.
REQ-004 SHALL have port irq, input, 1, maskable interrupt request; level sensitive.
REQ-005 SHALL have port irqEn, input, 1, IRQ enable flag from the register block.
REQ-006 SHALL have port brkReq, input, 1, one-cycle pulse from the decoder on BRK execution.
REQ-007 SHALL have port instrDone, input, 1, decoder pulse marking an instruction boundary.
REQ-008 SHALL have ports pcIn, spIn (input, 16) and flagsIn (input, 8): current PC, stack pointer and flags.
REQ-009 SHALL have port memReady, input, 1, memory controller has completed the current access.
REQ-010 SHALL have port memDIn, input, 8, read data from the memory controller.
REQ-011 SHALL have port memAddr, output, 16, access address.
REQ-012 SHALL have ports memRead and memWrite, output, 1 each, access requests; never both high.
REQ-013 SHALL have port memDOut, output, 8, write data.
REQ-014 SHALL have port spDec, output, 1, one-cycle pulse requesting an SP decrement.
REQ-015 SHALL have ports pcLoad (output, 1, one-cycle pulse) and pcOut (output, 16, new PC).
REQ-016 SHALL have port setIrqDisable, output, 1, one-cycle pulse clearing irqEn.
REQ-017 SHALL have ports intActive (output, 1, sequence in progress; decoder halts fetch) and intCause (output, 2): 00 reset, 01 NMI, 10 IRQ, 11 BRK; valid only while intActive=1.

Function
REQ-018 SHALL implement states RESET, IDLE, PUSH_PCH, PUSH_PCL, PUSH_FLG, VEC_LO, VEC_HI, LOAD.
REQ-019 SHALL set the NMI-pending latch on a 0->1 transition of nmiReq (registered previous value), in any state, and clear it on entry to PUSH_PCH for an NMI sequence.
REQ-020 SHALL set the BRK-pending latch on brkReq=1 and clear it on entry to PUSH_PCH for a BRK sequence.
REQ-021 SHALL arbitrate only in IDLE on a cycle with instrDone=1, with priority NMI-pending > BRK-pending > (irq AND irqEn); the winner moves IDLE->PUSH_PCH and latches intCause; with no winner the block stays in IDLE.
REQ-022 SHALL, in PUSH_PCH/PUSH_PCL/PUSH_FLG, drive memWrite=1, memAddr=spIn, memDOut=pcIn[15:8] / pcIn[7:0] / flagsIn; for BRK, flagsIn with bit 4 forced to 1, otherwise bit 4 forced to 0.
REQ-023 SHALL, in VEC_LO/VEC_HI, drive memRead=1, memAddr=vector / vector+1 and capture memDIn into the low / high byte; vector = 0xFFFC reset, 0xFFFA NMI, 0xFFFE IRQ and BRK.
REQ-024 SHALL hold each access state with all outputs stable until memReady=1 is sampled, then advance on that edge; spDec SHALL be high only in the push-state cycle where memReady=1.
REQ-025 SHALL, in LOAD, pulse pcLoad and setIrqDisable with pcOut={high,low}, then return to IDLE.
REQ-026 SHALL use latency with memReady tied high: arbitration at edge k gives PUSH_PCH in cycle k+1 and LOAD (pcLoad=1) in cycle k+6.
REQ-027 SHALL drive intActive=1 in every state except RESET and IDLE.
REQ-028 SHALL leave an NMI edge or BRK pulse arriving during a sequence pending, to be taken at the next arbitration.

Reset
REQ-029 SHALL, while resetReq=1, enter RESET, clear both pending latches and the captured vector, and drive all outputs 0; reset mid-sequence SHALL abort it with no pcLoad.
REQ-030 SHALL, on the first edge with resetReq=0, move RESET->VEC_LO with intCause=00, performing the vector fetch and LOAD with no pushes.

Verification
REQ-031 SHALL cover reset: resetReq high 3 cycles, memReady=1, mem[FFFC]=0x34, mem[FFFD]=0x12 -> reads FFFC, FFFD; pcLoad=1, pcOut=0x1234 on the 3rd cycle after release; no memWrite.
REQ-032 SHALL cover IRQ: irqEn=1, irq=1, pcIn=0x8005, spIn=0x01FF (model decrements), flagsIn=0x30, instrDone -> writes 0x80@01FF, 0x05@01FE, 0x20@01FD; reads FFFE/FFFF; pcLoad at k+6; setIrqDisable pulse.
REQ-033 SHALL cover masking: irq=1, irqEn=0, instrDone pulses -> intActive stays 0, no memory accesses.
REQ-034 SHALL cover priority: NMI edge, brkReq and irq all present at one instrDone -> intCause=01, vector FFFA; BRK taken at the next instrDone with the pushed flag byte having bit 4=1.
REQ-035 SHALL cover wait states: memReady=0 for 3 cycles in PUSH_PCL -> address/data held, a single spDec, pcLoad at k+9.
REQ-036 SHALL cover reset abort: resetReq=1 during VEC_HI of an NMI sequence -> no pcLoad from that sequence, NMI pending cleared, reset vector fetch follows release.

Source files
------------

// File: rtl/r88_intctl.sv
// r88_intctl: interrupt sequencer. Handles reset, NMI, IRQ and BRK.
// For NMI/IRQ/BRK it pushes PCH, PCL and flags, then fetches the vector
// and loads the PC. Reset skips the pushes and only fetches the vector.
module r88_intctl (
  input  logic        sysClock,
  input  logic        resetReq,
  input  logic        nmiReq,
  input  logic        irq,
  input  logic        irqEn,
  input  logic        brkReq,
  input  logic        instrDone,
  input  logic [15:0] pcIn,
  input  logic [15:0] spIn,
  input  logic [7:0]  flagsIn,
  input  logic        memReady,
  input  logic [7:0]  memDIn,
  output logic [15:0] memAddr,
  output logic        memRead,
  output logic        memWrite,
  output logic [7:0]  memDOut,
  output logic        spDec,
  output logic        pcLoad,
  output logic [15:0] pcOut,
  output logic        setIrqDisable,
  output logic        intActive,
  output logic [1:0]  intCause
);

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_PUSH_PCH, S_PUSH_PCL, S_PUSH_FLG, S_VEC_LO, S_VEC_HI, S_LOAD
  } state_e;

  localparam logic [1:0] C_RST = 2'b00;
  localparam logic [1:0] C_NMI = 2'b01;
  localparam logic [1:0] C_IRQ = 2'b10;
  localparam logic [1:0] C_BRK = 2'b11;

  state_e      state_q, state_d;
  logic [1:0]  cause_q, cause_d;
  logic        nmi_prev_q;
  logic        nmi_pend_q, nmi_pend_d;
  logic        brk_pend_q, brk_pend_d;
  logic [7:0]  lo_q, hi_q;
  logic        take_nmi, take_brk;
  logic [15:0] vector;

  // Vector base for the cause being serviced.
  always_comb begin
    case (cause_q)
      C_RST:   vector = 16'hFFFC;
      C_NMI:   vector = 16'hFFFA;
      default: vector = 16'hFFFE;
    endcase
  end

  // Next state. Arbitration only happens at an instruction boundary in IDLE.
  // Every access state waits for memReady before it advances.
  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    take_nmi = 1'b0;
    take_brk = 1'b0;
    case (state_q)
      S_RESET: begin
        state_d = S_VEC_LO;
        cause_d = C_RST;
      end
      S_IDLE: begin
        if (instrDone) begin
          if (nmi_pend_q) begin
            state_d  = S_PUSH_PCH;
            cause_d  = C_NMI;
            take_nmi = 1'b1;
          end else if (brk_pend_q) begin
            state_d  = S_PUSH_PCH;
            cause_d  = C_BRK;
            take_brk = 1'b1;
          end else if (irq && irqEn) begin
            state_d = S_PUSH_PCH;
            cause_d = C_IRQ;
          end
        end
      end
      S_PUSH_PCH: if (memReady) state_d = S_PUSH_PCL;
      S_PUSH_PCL: if (memReady) state_d = S_PUSH_FLG;
      S_PUSH_FLG: if (memReady) state_d = S_VEC_LO;
      S_VEC_LO:   if (memReady) state_d = S_VEC_HI;
      S_VEC_HI:   if (memReady) state_d = S_LOAD;
      S_LOAD:     state_d = S_IDLE;
      default:    state_d = S_RESET;
    endcase
  end

  // A new NMI edge or BRK pulse sets its latch even in the cycle a sequence
  // is taken, so a request that coincides with that cycle is not lost.
  always_comb begin
    nmi_pend_d = (nmi_pend_q & ~take_nmi) | (nmiReq & ~nmi_prev_q);
    brk_pend_d = (brk_pend_q & ~take_brk) | brkReq;
  end

  // State register, pending latches and vector capture.
  // nmi_prev_q keeps tracking during reset, so a level held across reset
  // does not look like a new edge after release.
  always_ff @(posedge sysClock) begin
    nmi_prev_q <= nmiReq;
    if (resetReq) begin
      state_q    <= S_RESET;
      cause_q    <= C_RST;
      nmi_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      lo_q       <= 8'h00;
      hi_q       <= 8'h00;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      nmi_pend_q <= nmi_pend_d;
      brk_pend_q <= brk_pend_d;
      if (state_q == S_VEC_LO && memReady) lo_q <= memDIn;
      if (state_q == S_VEC_HI && memReady) hi_q <= memDIn;
    end
  end

  // Outputs decode from the state. A reset request forces them all low at once.
  always_comb begin
    memAddr       = 16'h0000;
    memRead       = 1'b0;
    memWrite      = 1'b0;
    memDOut       = 8'h00;
    spDec         = 1'b0;
    pcLoad        = 1'b0;
    pcOut         = 16'h0000;
    setIrqDisable = 1'b0;
    intActive     = 1'b0;
    intCause      = 2'b00;
    if (!resetReq) begin
      intActive = (state_q != S_RESET) && (state_q != S_IDLE);
      intCause  = intActive ? cause_q : 2'b00;
      case (state_q)
        S_PUSH_PCH: begin
          memWrite = 1'b1; memAddr = spIn; memDOut = pcIn[15:8]; spDec = memReady;
        end
        S_PUSH_PCL: begin
          memWrite = 1'b1; memAddr = spIn; memDOut = pcIn[7:0]; spDec = memReady;
        end
        S_PUSH_FLG: begin
          memWrite = 1'b1; memAddr = spIn; spDec = memReady;
          memDOut  = {flagsIn[7:5], (cause_q == C_BRK), flagsIn[3:0]};
        end
        S_VEC_LO: begin
          memRead = 1'b1; memAddr = vector;
        end
        S_VEC_HI: begin
          memRead = 1'b1; memAddr = vector + 16'd1;
        end
        S_LOAD: begin
          pcLoad = 1'b1; setIrqDisable = 1'b1; pcOut = {hi_q, lo_q};
        end
        default: ;
      endcase
    end
  end

endmodule
